// File: rtl/mipi_csi_rx_packet_parser.sv
// CSI-2 RX packet parser: assembles the 4-byte header, splits short/long packets,
// forwards WC-masked payload bytes, captures the 16-bit footer and flags truncation.
module mipi_csi_rx_packet_parser #(
    parameter int unsigned NUM_LANES   = 4,
    parameter int unsigned CNT_W       = 16,
    parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_LANES-1:0]   data_valid_i,
    input  logic [NUM_LANES*8-1:0] data_i,
    input  logic [2:0]             active_lanes_i,
    input  logic [CNT_W-1:0]       word_count_i,
    input  logic                   ecc_fatal_i,
    output logic [31:0]            packet_header_o,
    output logic                   header_valid_o,
    output logic [1:0]             vc_o,
    output logic [5:0]             dt_o,
    output logic                   short_pkt_valid_o,
    output logic [NUM_LANES*8-1:0] payload_data_o,
    output logic [NUM_LANES-1:0]   payload_valid_o,
    output logic                   payload_last_o,
    output logic [15:0]            received_crc_o,
    output logic                   crc_valid_o,
    output logic                   wc_err_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_EVAL,
        S_PAYLOAD,
        S_CRC,
        S_DROP
    } state_e;

    // Byte indices carry two spare bits so WC+1 never wraps at the largest word count.
    localparam int unsigned      IDX_W   = CNT_W + 2;
    localparam int unsigned      SUM_W   = CNT_W + 1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q, state_d;
    logic [2:0]             lanes_q, lanes_d;
    logic [31:0]            hdr_q, hdr_d;
    logic [2:0]             hdr_cnt_q, hdr_cnt_d;
    logic                   hdr_valid_q, hdr_valid_d;
    logic [1:0]             vc_q, vc_d;
    logic [5:0]             dt_q, dt_d;
    logic [CNT_W-1:0]       wc_q, wc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LANES*8-1:0] pl_data_q, pl_data_d;
    logic [NUM_LANES-1:0]   pl_valid_q, pl_valid_d;
    logic                   pl_last_q, pl_last_d;
    logic [7:0]             crc_lsb_q, crc_lsb_d;
    logic [15:0]            rx_crc_q, rx_crc_d;
    logic                   crc_valid_q, crc_valid_d;
    logic                   wc_err_q, wc_err_d;

    logic                   active;
    logic [2:0]             lanes_sane;
    logic [2:0]             lanes_eff;
    logic [NUM_LANES-1:0]   lane_en;
    logic [2:0]             beat_bytes;
    logic [2:0]             hdr_base;
    logic [31:0]            hdr_asm;
    logic                   hdr_complete;
    logic [CNT_W-1:0]       wc_eff;
    logic [IDX_W-1:0]       wc_ext;
    logic [IDX_W-1:0]       byte_idx;
    logic [SUM_W-1:0]       cnt_sum;
    logic [CNT_W-1:0]       cnt_sat;
    logic [NUM_LANES*8-1:0] body_data;
    logic [NUM_LANES-1:0]   body_valid;
    logic                   body_last;
    logic                   footer_done;
    logic [7:0]             body_lsb;
    logic [15:0]            body_crc;

    // Unsupported lane counts fall back to a single lane.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
        lanes_sane = 3'd1;
        if (active_lanes_i == 3'd2 && NUM_LANES >= 2) lanes_sane = 3'd2;
        if (active_lanes_i == 3'd4 && NUM_LANES >= 4) lanes_sane = 3'd4;
    end

    always_comb begin
        active    = |data_valid_i;
        lanes_eff = (state_q == S_IDLE) ? lanes_sane : lanes_q;
        hdr_base  = (state_q == S_IDLE) ? 3'd0 : hdr_cnt_q;
        wc_eff    = (state_q == S_EVAL) ? word_count_i : wc_q;
        wc_ext    = IDX_W'(wc_eff);

        lane_en    = '0;
        beat_bytes = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_en[k] = data_valid_i[k] && (k < int'(lanes_eff));
            beat_bytes = beat_bytes + 3'(lane_en[k]);
        end

        // Header byte n lands in hdr_asm[31-8n -: 8], giving {DI, WC_lsb, WC_msb, ECC}.
        hdr_asm = hdr_q;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (lane_en[k] && (int'(hdr_base) + k < 4))
                hdr_asm[8*(3 - (int'(hdr_base) + k)) +: 8] = data_i[8*k +: 8];
        end
        hdr_complete = (int'(hdr_base) + int'(beat_bytes)) >= 4;

        body_data   = '0;
        body_valid  = '0;
        body_last   = 1'b0;
        footer_done = 1'b0;
        body_lsb    = crc_lsb_q;
        body_crc    = rx_crc_q;
        byte_idx    = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            byte_idx = IDX_W'(cnt_q) + IDX_W'(k);
            if (lane_en[k]) begin
                if (byte_idx < wc_ext) begin
                    body_valid[k]       = 1'b1;
                    body_data[8*k +: 8] = data_i[8*k +: 8];
                    if (byte_idx + IDX_ONE == wc_ext) body_last = 1'b1;
                end else if (byte_idx == wc_ext) begin
                    body_lsb = data_i[8*k +: 8];
                end else if (byte_idx == wc_ext + IDX_ONE) begin
                    body_crc    = {data_i[8*k +: 8], body_lsb};
                    footer_done = 1'b1;
                end
            end
        end

        cnt_sum = SUM_W'(cnt_q) + SUM_W'(beat_bytes);
        cnt_sat = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        lanes_d     = lanes_q;
        hdr_d       = hdr_q;
        hdr_cnt_d   = hdr_cnt_q;
        hdr_valid_d = 1'b0;
        vc_d        = vc_q;
        dt_d        = dt_q;
        wc_d        = wc_q;
        cnt_d       = cnt_q;
        pl_data_d   = '0;
        pl_valid_d  = '0;
        pl_last_d   = 1'b0;
        crc_lsb_d   = crc_lsb_q;
        rx_crc_d    = rx_crc_q;
        crc_valid_d = 1'b0;
        wc_err_d    = 1'b0;

        case (state_q)
            S_IDLE, S_HDR: begin
                if (!active) begin
                    hdr_cnt_d = '0;
                    if (state_q == S_HDR) begin
                        wc_err_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end else begin
                    if (state_q == S_IDLE) lanes_d = lanes_sane;
                    hdr_d = hdr_asm;
                    if (hdr_complete) begin
                        hdr_valid_d = 1'b1;
                        vc_d        = hdr_asm[31:30];
                        dt_d        = hdr_asm[29:24];
                        hdr_cnt_d   = '0;
                        cnt_d       = '0;
                        state_d     = S_EVAL;
                    end else begin
                        hdr_cnt_d = hdr_base + beat_bytes;
                        state_d   = S_HDR;
                    end
                end
            end
            // S_EVAL is the header_valid_o cycle: WC and ECC verdict arrive now and a
            // payload beat may already be present, so it shares the body path.
            S_EVAL, S_PAYLOAD, S_CRC: begin
                if (state_q == S_EVAL) wc_d = word_count_i;
                if (state_q == S_EVAL && (ecc_fatal_i || dt_q < LONG_DT_MIN)) begin
                    state_d = S_DROP;
                end else if (!active) begin
                    wc_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d      = cnt_sat;
                    pl_data_d  = body_data;
                    pl_valid_d = body_valid;
                    pl_last_d  = body_last;
                    crc_lsb_d  = body_lsb;
                    if (footer_done) begin
                        rx_crc_d    = body_crc;
                        crc_valid_d = 1'b1;
                        state_d     = S_DROP;
                    end else begin
                        state_d = (cnt_sat >= wc_eff) ? S_CRC : S_PAYLOAD;
                    end
                end
            end
            S_DROP: begin
                if (!active) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            lanes_q     <= 3'd1;
            hdr_q       <= '0;
            hdr_cnt_q   <= '0;
            hdr_valid_q <= 1'b0;
            vc_q        <= '0;
            dt_q        <= '0;
            wc_q        <= '0;
            cnt_q       <= '0;
            pl_data_q   <= '0;
            pl_valid_q  <= '0;
            pl_last_q   <= 1'b0;
            crc_lsb_q   <= '0;
            rx_crc_q    <= '0;
            crc_valid_q <= 1'b0;
            wc_err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            hdr_q       <= hdr_d;
            hdr_cnt_q   <= hdr_cnt_d;
            hdr_valid_q <= hdr_valid_d;
            vc_q        <= vc_d;
            dt_q        <= dt_d;
            wc_q        <= wc_d;
            cnt_q       <= cnt_d;
            pl_data_q   <= pl_data_d;
            pl_valid_q  <= pl_valid_d;
            pl_last_q   <= pl_last_d;
            crc_lsb_q   <= crc_lsb_d;
            rx_crc_q    <= rx_crc_d;
            crc_valid_q <= crc_valid_d;
            wc_err_q    <= wc_err_d;
        end
    end

    // The ECC verdict is only valid alongside header_valid_o, so the short flag is qualified live.
    assign packet_header_o   = hdr_valid_q ? hdr_q : 32'h0;
    assign header_valid_o    = hdr_valid_q;
    assign vc_o              = vc_q;
    assign dt_o              = dt_q;
    assign short_pkt_valid_o = hdr_valid_q && (dt_q < LONG_DT_MIN) && !ecc_fatal_i;
    assign payload_data_o    = pl_data_q;
    assign payload_valid_o   = pl_valid_q;
    assign payload_last_o    = pl_last_q;
    assign received_crc_o    = rx_crc_q;
    assign crc_valid_o       = crc_valid_q;
    assign wc_err_o          = wc_err_q;
    assign busy_o            = (state_q != S_IDLE);

endmodule

// File: tb/tb_mipi_csi_rx_packet_parser.sv
// Scoreboard bench for the CSI-2 RX packet parser: packets are built as byte streams,
// expected header/payload/footer/error events are queued and matched against DUT pulses.
module tb_mipi_csi_rx_packet_parser;

    localparam int NL = 4;
    localparam int CW = 16;

    logic            clk_i = 1'b0;
    logic            reset_i;
    logic [NL-1:0]   data_valid_i;
    logic [NL*8-1:0] data_i;
    logic [2:0]      active_lanes_i;
    logic [CW-1:0]   word_count_i;
    logic            ecc_fatal_i;
    logic [31:0]     packet_header_o;
    logic            header_valid_o;
    logic [1:0]      vc_o;
    logic [5:0]      dt_o;
    logic            short_pkt_valid_o;
    logic [NL*8-1:0] payload_data_o;
    logic [NL-1:0]   payload_valid_o;
    logic            payload_last_o;
    logic [15:0]     received_crc_o;
    logic            crc_valid_o;
    logic            wc_err_o;
    logic            busy_o;

    mipi_csi_rx_packet_parser #(
        .NUM_LANES  (NL),
        .CNT_W      (CW),
        .LONG_DT_MIN(6'h10)
    ) dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .data_valid_i     (data_valid_i),
        .data_i           (data_i),
        .active_lanes_i   (active_lanes_i),
        .word_count_i     (word_count_i),
        .ecc_fatal_i      (ecc_fatal_i),
        .packet_header_o  (packet_header_o),
        .header_valid_o   (header_valid_o),
        .vc_o             (vc_o),
        .dt_o             (dt_o),
        .short_pkt_valid_o(short_pkt_valid_o),
        .payload_data_o   (payload_data_o),
        .payload_valid_o  (payload_valid_o),
        .payload_last_o   (payload_last_o),
        .received_crc_o   (received_crc_o),
        .crc_valid_o      (crc_valid_o),
        .wc_err_o         (wc_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] hdr;
        logic        short_v;
    } hdr_exp_t;

    typedef struct {
        logic [NL*8-1:0] data;
        logic [NL-1:0]   valid;
        logic            last;
    } beat_exp_t;

    hdr_exp_t    exp_hdr[$];
    beat_exp_t   exp_beat[$];
    logic [15:0] exp_crc[$];
    int          exp_err = 0;
    int          n_cmp   = 0;
    int          n_bad   = 0;
    bit          mon_en  = 1'b0;
    hdr_exp_t    mh;
    beat_exp_t   mb;
    logic [15:0] mc;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_hdr"},       packet_header_o,   0);
        check({pfx, "_hdr_v"},     header_valid_o,    0);
        check({pfx, "_vc"},        vc_o,              0);
        check({pfx, "_dt"},        dt_o,              0);
        check({pfx, "_short"},     short_pkt_valid_o, 0);
        check({pfx, "_pl_data"},   payload_data_o,    0);
        check({pfx, "_pl_valid"},  payload_valid_o,   0);
        check({pfx, "_pl_last"},   payload_last_o,    0);
        check({pfx, "_crc"},       received_crc_o,    0);
        check({pfx, "_crc_valid"}, crc_valid_o,       0);
        check({pfx, "_wc_err"},    wc_err_o,          0);
        check({pfx, "_busy"},      busy_o,            0);
    endtask

    // Output monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        if (mon_en && !reset_i) begin
            if (header_valid_o) begin
                check("hdr_expected", 32'(exp_hdr.size() != 0), 1);
                if (exp_hdr.size() != 0) begin
                    mh = exp_hdr.pop_front();
                    check("hdr",   packet_header_o,   mh.hdr);
                    check("vc",    vc_o,              mh.hdr[31:30]);
                    check("dt",    dt_o,              mh.hdr[29:24]);
                    check("short", short_pkt_valid_o, mh.short_v);
                end
            end else begin
                check("hdr_idle_zero", packet_header_o,   0);
                check("short_stray",   short_pkt_valid_o, 0);
            end
            if (payload_valid_o != '0) begin
                check("beat_expected", 32'(exp_beat.size() != 0), 1);
                if (exp_beat.size() != 0) begin
                    mb = exp_beat.pop_front();
                    check("pl_valid", payload_valid_o, mb.valid);
                    check("pl_data",  payload_data_o,  mb.data);
                    check("pl_last",  payload_last_o,  mb.last);
                end
            end else begin
                check("pl_last_stray", payload_last_o, 0);
            end
            if (crc_valid_o) begin
                check("crc_expected", 32'(exp_crc.size() != 0), 1);
                if (exp_crc.size() != 0) begin
                    mc = exp_crc.pop_front();
                    check("crc", received_crc_o, mc);
                end
            end
            if (wc_err_o) begin
                check("wc_err_expected", 32'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
                check("busy_after_err", busy_o, 0);
            end
        end
    end

    task automatic send_pkt(input int lanes, input logic [2:0] lanes_cfg, input logic [7:0] di,
                            input logic [15:0] wc, input logic [15:0] crc, input logic fatal,
                            input int n_send);
        logic [7:0] s[$];
        hdr_exp_t   he;
        beat_exp_t  be;
        logic [7:0] ecc;
        int         nb;
        int         p;
        bit         is_long;
        ecc = 8'($urandom);
        s.push_back(di);
        s.push_back(wc[7:0]);
        s.push_back(wc[15:8]);
        s.push_back(ecc);
        for (int i = 0; i < int'(wc); i++) s.push_back(8'($urandom));
        s.push_back(crc[7:0]);
        s.push_back(crc[15:8]);
        while (s.size() < n_send) s.push_back(8'($urandom));

        is_long = (di[5:0] >= 6'h10) && !fatal;
        if (n_send < 4) begin
            exp_err++;
        end else begin
            he.hdr     = {di, wc[7:0], wc[15:8], ecc};
            he.short_v = (di[5:0] < 6'h10) && !fatal;
            exp_hdr.push_back(he);
            if (is_long) begin
                for (int b0 = 0; b0 < int'(wc) && b0 < n_send - 4; b0 += lanes) begin
                    be.data  = '0;
                    be.valid = '0;
                    be.last  = 1'b0;
                    for (int k = 0; k < lanes; k++) begin
                        p = b0 + k;
                        if (p < int'(wc) && p < n_send - 4) begin
                            be.valid[k]       = 1'b1;
                            be.data[8*k +: 8] = s[4+p];
                            if (p == int'(wc) - 1) be.last = 1'b1;
                        end
                    end
                    exp_beat.push_back(be);
                end
                if (n_send >= 4 + int'(wc) + 2) exp_crc.push_back(crc);
                else exp_err++;
            end
        end

        word_count_i = wc;
        ecc_fatal_i  = fatal;
        nb = (n_send + lanes - 1) / lanes;
        for (int j = 0; j < nb; j++) begin
            @(posedge clk_i); #1;
            active_lanes_i = (j == 0) ? lanes_cfg : 3'($urandom_range(0, 7));
            for (int k = 0; k < NL; k++) begin
                p = j * lanes + k;
                if (k < lanes && p < n_send) begin
                    data_valid_i[k]   = 1'b1;
                    data_i[8*k +: 8]  = s[p];
                end else begin
                    data_valid_i[k]   = 1'b0;
                    data_i[8*k +: 8]  = 8'($urandom);
                end
            end
        end
        @(posedge clk_i); #1;
        data_valid_i = '0;
        data_i       = $urandom;
        repeat (4) @(posedge clk_i);
    endtask

    initial begin
        reset_i        = 1'b1;
        data_valid_i   = '0;
        data_i         = '0;
        active_lanes_i = 3'd4;
        word_count_i   = '0;
        ecc_fatal_i    = 1'b0;
        repeat (3) @(posedge clk_i); #1;
        check_zero("reset");
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        mon_en = 1'b1;

        send_pkt(4, 3'd4, 8'h2A, 16'd6,      16'h1234, 1'b0, 12);  // payload + footer in 2 beats
        send_pkt(1, 3'd1, 8'h00, 16'h0001,   16'h0000, 1'b0, 4);   // short packet, 1 lane
        send_pkt(2, 3'd2, 8'h2B, 16'd0,      16'hABCD, 1'b0, 6);   // long, WC=0
        send_pkt(4, 3'd4, 8'h2A, 16'd10,     16'h5555, 1'b0, 12);  // truncated after 8 bytes
        send_pkt(4, 3'd4, 8'h2A, 16'd5,      16'h7777, 1'b1, 11);  // ECC fatal -> drop
        send_pkt(2, 3'd2, 8'hE4, 16'd7,      16'hBEEF, 1'b0, 16);  // vc=3, trailing filler
        check("vc_held", vc_o, 2'd3);
        check("dt_held", dt_o, 6'h24);
        send_pkt(1, 3'd3, 8'h6A, 16'd3,      16'hC0DE, 1'b0, 9);   // illegal lane cfg -> 1 lane
        send_pkt(2, 3'd2, 8'h2A, 16'd4,      16'h0000, 1'b0, 2);   // header truncated
        send_pkt(4, 3'd4, 8'h2A, 16'd7,      16'hF00D, 1'b0, 13);  // footer straddles beats
        send_pkt(2, 3'd2, 8'hC1, 16'h1234,   16'h0000, 1'b0, 4);   // short with vc=3

        // Reset mid-payload of a WC=100 packet; the monitor is parked for this one.
        mon_en       = 1'b0;
        word_count_i = 16'd100;
        ecc_fatal_i  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clk_i); #1;
            active_lanes_i = 3'd4;
            data_valid_i   = '1;
            data_i         = (j == 0) ? {8'h11, 8'h00, 8'd100, 8'h2A} : $urandom;
        end
        @(posedge clk_i); #1;
        check("busy_before_rst", busy_o, 1);
        check("pl_before_rst", payload_valid_o, 4'hF);
        reset_i      = 1'b1;
        data_valid_i = '0;
        #1;
        check_zero("midrst");
        repeat (2) @(posedge clk_i); #1;
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        mon_en = 1'b1;

        send_pkt(4, 3'd4, 8'h6A, 16'd9, 16'h4321, 1'b0, 15);  // parsed normally after reset

        repeat (6) @(posedge clk_i); #1;
        check("hdr_left",  exp_hdr.size(),  0);
        check("beat_left", exp_beat.size(), 0);
        check("crc_left",  exp_crc.size(),  0);
        check("err_left",  exp_err,         0);
        check("busy_end",  busy_o,          0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
